// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer and its bench.
package systolic_pkg;

    // Phases of one matrix-multiply pass.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Zero-fill cycles needed after the last row: skewer depth 2N-1 plus N array hops.
    function automatic int drain_cycles(input int n);
        return 3 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Host/buffer/skewer-facing signal bundle of the systolic sequencer.
// The master modport is the sequencer's view; the slave modport is the surroundings.
interface systolic_sequencer_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
);
    localparam int ADDR_W = $clog2(MATRIX_SIZE);

    logic                   start;
    logic                   stall;
    logic                   busy;
    logic                   done;
    logic                   pe_clear;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_SIZE-1:0]   buf_data  [MATRIX_SIZE];
    logic                   skew_en;
    logic [DATA_SIZE-1:0]   skew_data [MATRIX_SIZE];

    modport master (
        input  start, stall, buf_data,
        output busy, done, pe_clear, rd_en, rd_addr, skew_en, skew_data
    );

    modport slave (
        output start, stall, buf_data,
        input  busy, done, pe_clear, rd_en, rd_addr, skew_en, skew_data
    );

endinterface

// File: rtl/systolic_sequencer_seq_counter.sv
// Loadable up-counter with enable, clear and terminal-count compare.
// Priority is reset, then clear, then load, then increment.
module seq_counter #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_terminal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_atTerminal
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear/load win over the increment so a phase change restarts cleanly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count      = r_count;
    assign o_atTerminal = (r_count == i_terminal);

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one matrix-multiply pass: clear the PE accumulators, stream N operand
// rows into the input skewer, zero-fill until the pipelines drain, then pulse done.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE  = 2,
    parameter int DATA_SIZE    = 32,
    parameter int DRAIN_CYCLES = drain_cycles(MATRIX_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    systolic_sequencer_if.master  bus
);

    localparam int ADDR_W  = $clog2(MATRIX_SIZE);
    localparam int CNT_MAX = (MATRIX_SIZE > DRAIN_CYCLES) ? MATRIX_SIZE : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_t       r_state;
    seq_state_t       w_nextState;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_terminal;
    logic             w_atTerminal;
    logic             w_cntClear;
    logic             w_cntLoad;
    logic             w_cntEn;
    logic             w_feedGo;
    logic             w_drainGo;

    // A FEED or DRAIN cycle only makes progress when downstream is not stalling.
    assign w_feedGo  = (r_state == ST_FEED)  && !bus.stall;
    assign w_drainGo = (r_state == ST_DRAIN) && !bus.stall;

    // Row / drain counter; restarts from zero at the FEED to DRAIN boundary.
    seq_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_clear      (w_cntClear),
        .i_load       (w_cntLoad),
        .i_loadValue  ('0),
        .i_en         (w_cntEn),
        .i_terminal   (w_terminal),
        .o_count      (w_cnt),
        .o_atTerminal (w_atTerminal)
    );

    // Counter control: terminal depends on phase, load-to-zero when the last row issues.
    always_comb begin
        w_terminal = (r_state == ST_DRAIN) ? DRAIN_LAST : FEED_LAST;
        w_cntEn    = w_feedGo || w_drainGo;
        w_cntLoad  = w_feedGo && w_atTerminal;
        w_cntClear = (r_state == ST_IDLE) || (r_state == ST_CLEAR) || (r_state == ST_DONE);
    end

    // State register; reset abandons any partial pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: start is only honoured in IDLE, CLEAR and DONE last one cycle each.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_nextState = ST_CLEAR;
            ST_CLEAR: w_nextState = ST_FEED;
            ST_FEED:  if (w_feedGo && w_atTerminal) w_nextState = ST_DRAIN;
            ST_DRAIN: if (w_drainGo && w_atTerminal) w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Outputs decoded from state/count; stall gates the strobes and zeroes skew data.
    always_comb begin
        bus.busy     = (r_state != ST_IDLE);
        bus.done     = (r_state == ST_DONE);
        bus.pe_clear = (r_state == ST_CLEAR);
        bus.rd_en    = w_feedGo;
        bus.rd_addr  = (r_state == ST_FEED) ? ADDR_W'(w_cnt) : '0;
        bus.skew_en  = w_feedGo || w_drainGo;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            bus.skew_data[i] = w_feedGo ? bus.buf_data[i] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: directed vector table plus a
// randomized run compared against a work-list reference model.
module tb_systolic_sequencer;
    import systolic_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int D  = drain_cycles(N);
    localparam int K_CLR  = -1;
    localparam int K_ZERO = 100;
    localparam int K_DONE = 200;

    typedef struct {
        bit busy, done, clr, rden;
        int addr;
        bit sken;
        logic [N-1:0][DW-1:0] data;
    } exp_t;

    typedef struct {
        string tag;
        bit st, sl, rs;
        bit by, dn, cl, rd;
        int ad;
        bit se;
        int row;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] mem [N][N];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    vec_t vecs[$];
    int   q[$];

    always #5 clk = ~clk;

    systolic_sequencer_if #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) bus();

    systolic_sequencer #(
        .MATRIX_SIZE  (N),
        .DATA_SIZE    (DW),
        .DRAIN_CYCLES (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Operand buffer: combinational read of the requested row.
    always_comb begin
        for (int e = 0; e < N; e++) begin
            bus.buf_data[e] = mem[bus.rd_addr][e];
        end
    end

    function automatic exp_t mkExp(bit by, bit dn, bit cl, bit rd, int ad, bit se, int row);
        exp_t e;
        e.busy = by; e.done = dn; e.clr = cl; e.rden = rd; e.addr = ad; e.sken = se;
        for (int k = 0; k < N; k++) begin
            e.data[k] = (row >= 0) ? mem[row][k] : '0;
        end
        return e;
    endfunction

    // Reference model: a pass is a work list of CLEAR, N rows, D zero fills and DONE.
    function automatic exp_t modelExp(bit sl);
        int h;
        bit feed, drain;
        if (q.size() == 0) return mkExp(0, 0, 0, 0, 0, 0, -1);
        h     = q[0];
        feed  = (h >= 0) && (h < N);
        drain = (h == K_ZERO);
        return mkExp(1, h == K_DONE, h == K_CLR, feed && !sl, feed ? h : 0,
                     (feed || drain) && !sl, (feed && !sl) ? h : -1);
    endfunction

    function automatic void modelStep(bit st, bit sl, bit rs);
        int h;
        if (rs) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (st) begin
                q.push_back(K_CLR);
                for (int r = 0; r < N; r++) q.push_back(r);
                for (int z = 0; z < D; z++) q.push_back(K_ZERO);
                q.push_back(K_DONE);
            end
        end else begin
            h = q[0];
            if (!(sl && (h == K_ZERO || (h >= 0 && h < N)))) void'(q.pop_front());
        end
    endfunction

    function automatic void addVec(string tag, bit st, bit sl, bit rs, bit by, bit dn,
                                   bit cl, bit rd, int ad, bit se, int row);
        vec_t v;
        v.tag = tag; v.st = st; v.sl = sl; v.rs = rs; v.by = by; v.dn = dn;
        v.cl = cl; v.rd = rd; v.ad = ad; v.se = se; v.row = row;
        vecs.push_back(v);
    endfunction

    function automatic void idleV(string t, bit st);         addVec(t, st, 0, 0, 0, 0, 0, 0, 0, 0, -1); endfunction
    function automatic void clearV(string t, bit st);        addVec(t, st, 0, 0, 1, 0, 1, 0, 0, 0, -1); endfunction
    function automatic void feedV(string t, bit st, int r);  addVec(t, st, 0, 0, 1, 0, 0, 1, r, 1, r);  endfunction
    function automatic void feedStallV(string t, int r);     addVec(t, 0, 1, 0, 1, 0, 0, 0, r, 0, -1);  endfunction
    function automatic void drainV(string t, bit st, bit sl); addVec(t, st, sl, 0, 1, 0, 0, 0, 0, !sl, -1); endfunction
    function automatic void doneV(string t, bit st);         addVec(t, st, 0, 0, 1, 1, 0, 0, 0, 0, -1); endfunction

    function automatic void basicPass(string t);
        idleV(t, 1); clearV(t, 0); feedV(t, 0, 0); feedV(t, 0, 1);
        for (int z = 0; z < D; z++) drainV(t, 0, 0);
        doneV(t, 0); idleV(t, 0);
    endfunction

    task automatic applyStimulus(input bit st, input bit sl, input bit rs);
        bus.start = st;
        bus.stall = sl;
        reset     = rs;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkVal({tag, ".busy"},     64'(bus.busy),     64'(e.busy));
        checkVal({tag, ".done"},     64'(bus.done),     64'(e.done));
        checkVal({tag, ".pe_clear"}, 64'(bus.pe_clear), 64'(e.clr));
        checkVal({tag, ".rd_en"},    64'(bus.rd_en),    64'(e.rden));
        checkVal({tag, ".rd_addr"},  64'(bus.rd_addr),  64'(e.addr));
        checkVal({tag, ".skew_en"},  64'(bus.skew_en),  64'(e.sken));
        for (int k = 0; k < N; k++) begin
            checkVal($sformatf("%s.skew_data%0d", tag, k), 64'(bus.skew_data[k]), 64'(e.data[k]));
        end
    endtask

    initial begin
        int  busyCnt;
        bit  doneSeen;
        bit  st, sl, rs;

        mem[0][0] = 32'hA0; mem[0][1] = 32'hA1;
        mem[1][0] = 32'hB0; mem[1][1] = 32'hB1;

        // Build the directed vector table.
        basicPass("basic");
        idleV("stall", 1); clearV("stall", 0); feedV("stall", 0, 0); feedStallV("stall", 1);
        feedV("stall", 0, 1); drainV("stall", 0, 0); drainV("stall", 0, 1);
        for (int z = 0; z < D - 1; z++) drainV("stall", 0, 0);
        doneV("stall", 0); idleV("stall", 0);
        idleV("held", 1); clearV("held", 1); feedV("held", 1, 0); feedV("held", 1, 1);
        for (int z = 0; z < D; z++) drainV("held", 1, 0);
        doneV("held", 1); idleV("held", 1); clearV("held", 0); feedV("held", 0, 0); feedV("held", 0, 1);
        for (int z = 0; z < D; z++) drainV("held", 0, 0);
        doneV("held", 0); idleV("held", 0);
        idleV("rstmid", 1); clearV("rstmid", 0); feedV("rstmid", 0, 0); feedV("rstmid", 0, 1);
        drainV("rstmid", 0, 0); drainV("rstmid", 0, 0);
        addVec("rstmid", 0, 0, 1, 1, 0, 0, 0, 0, 1, -1);
        addVec("rstmid", 1, 0, 1, 0, 0, 0, 0, 0, 0, -1);
        idleV("rstmid", 0);
        basicPass("fresh");

        // Reset state.
        applyStimulus(0, 0, 1);
        stepClock();
        stepClock();
        @(negedge clk);
        checkOutput("reset", mkExp(0, 0, 0, 0, 0, 0, -1));
        stepClock();
        applyStimulus(0, 0, 0);
        stepClock();

        // Directed table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].sl, vecs[i].rs);
            @(negedge clk);
            checkOutput(vecs[i].tag, mkExp(vecs[i].by, vecs[i].dn, vecs[i].cl, vecs[i].rd,
                                           vecs[i].ad, vecs[i].se, vecs[i].row));
            stepClock();
        end

        // Busy length of an unstalled pass, bounded wait for done.
        applyStimulus(1, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0);
        busyCnt  = 0;
        doneSeen = 1'b0;
        for (int k = 0; k < 40 && !doneSeen; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.done === 1'b1) doneSeen = 1'b1;
            stepClock();
        end
        checkVal("doneSeen", 64'(doneSeen), 64'd1);
        checkVal("busyLen", 64'(busyCnt), 64'(N + D + 2));

        // Randomized run against the work-list model.
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 3) == 0);
            rs = (c == 0) || ($urandom_range(0, 99) == 0);
            applyStimulus(st, sl, rs);
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) mem[r][k] = $urandom;
            end
            @(negedge clk);
            checkOutput("rand", modelExp(sl));
            stepClock();
            modelStep(st, sl, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
